// File: rtl/seven_seg_decoder.sv
// Registered hex-to-seven-segment decoder for one display digit.
// hex_out is driven straight from the segment register; the polarity is fixed by ACTIVE_LOW.
module seven_seg_decoder #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bin_in,
    input  logic       en,
    input  logic       blank,
    output logic [6:0] hex_out
);

    // XOR with this mask converts a lit-segment pattern into pin drive levels.
    localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] BLANK_DRIVE = POL_MASK;

    logic [6:0] lit;
    logic [6:0] seg_q;

    // Lit-segment form, with bit 6 = g and bit 0 = a. Lowercase b and d keep them distinct from 8 and 0.
    always_comb begin
        lit = 7'h00;
        case (bin_in)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            4'hF: lit = 7'h71;
            default: lit = 7'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            seg_q <= BLANK_DRIVE;
        else if (en)
            seg_q <= blank ? BLANK_DRIVE : (lit ^ POL_MASK);
    end

    assign hex_out = seg_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder. It drives both polarities from shared inputs and checks them
// against a table-driven model of the digit that should currently be lit.
module tb_seven_seg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bin_in;
    logic       en;
    logic       blank;
    logic [6:0] hex_al;
    logic [6:0] hex_ah;

    int checks = 0;
    int failures = 0;

    // Lit-segment patterns for digits 0..F, copied from the digit shapes.
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] shown;   // segments expected lit right now

    always #5 clk = ~clk;

    seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .bin_in(bin_in), .en(en), .blank(blank), .hex_out(hex_al)
    );
    seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst(rst), .bin_in(bin_in), .en(en), .blank(blank), .hex_out(hex_ah)
    );

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_al"}, hex_al, ~shown);
        chk({tag, "_ah"}, hex_ah, shown);
    endtask

    // Advance one clock, update the model from the inputs present at the edge, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst && en) shown = blank ? 7'h00 : tbl[bin_in];
        #1;
        chk_both(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; blank = 1'b0; bin_in = 4'h0;
        shown = 7'h00;
        #1 chk_both("reset_async");
        chk("reset_al_7f", hex_al, 7'h7F);

        rst = 1'b0;
        repeat (3) tick("reset_hold");

        // Check the full sweep against the inverted values the plan lists for ACTIVE_LOW=1.
        begin
            logic [6:0] sweep_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
            en = 1'b1;
            for (int i = 0; i < 16; i++) begin
                bin_in = 4'(i);
                tick("sweep");
                chk("sweep_lit", hex_al, sweep_al[i]);
            end
        end

        bin_in = 4'h5; tick("hold_cap");
        chk("hold_cap_12", hex_al, 7'h12);
        en = 1'b0; bin_in = 4'h8;
        repeat (4) tick("hold");
        chk("hold_12", hex_al, 7'h12);

        en = 1'b1; blank = 1'b1; bin_in = 4'h8;
        tick("blank_on");
        chk("blank_7f", hex_al, 7'h7F);
        blank = 1'b0;
        tick("blank_off");
        chk("blank_off_00", hex_al, 7'h00);

        // blank drops while en is low, so the digit has to stay dark until the next enabled edge.
        blank = 1'b1; tick("blank_set");
        en = 1'b0; blank = 1'b0;
        repeat (2) tick("blank_held");
        en = 1'b1; tick("blank_release");

        // Assert reset between edges partway through a sweep.
        for (int i = 0; i < 10; i++) begin
            bin_in = 4'(i);
            tick("mid_sweep");
            if (i == 6) begin
                #2 rst = 1'b1; shown = 7'h00;
                #1 chk_both("mid_rst_async");
                tick("mid_rst_edge");
                rst = 1'b0;
            end
        end

        // Random traffic. Reset changes between edges and takes effect at once.
        for (int n = 0; n < 300; n++) begin
            en     = ($urandom_range(0, 3) != 0);
            blank  = ($urandom_range(0, 7) == 0);
            bin_in = 4'($urandom_range(0, 15));
            rst    = ($urandom_range(0, 19) == 0);
            if (rst) shown = 7'h00;
            #1 chk_both("rand_async");
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_decoder.md
# seven_seg_decoder

Registered hexadecimal-to-seven-segment decoder for the piano's on-board display path. It converts a 4-bit binary nibble (0–F) into the segment pattern for one common-anode digit, registers the result, and drives the segment pins. It sits between the note/status logic that produces the nibble and the display-digit multiplexer or segment pins.

## Interface
Parameters:
- ACTIVE_LOW, default 1, segment polarity: 1 means a lit segment drives 0; 0 means a lit segment drives 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bin_in  input  4  binary nibble to display, 0x0–0xF.
- en  input  1  load enable; when 1, the output register captures the decode of bin_in.
- blank  input  1  when 1, the next captured pattern is all segments off, regardless of bin_in.
- hex_out  output  7  registered segment drive, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.

## Operation
- Decode table, lit-segment (active-high) form, bits g..a:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- Lowercase b and d are used so they are not confused with 8 and 0.
- With ACTIVE_LOW=1, hex_out is the bitwise inverse of the table. For example, 0 becomes 0x40, 8 becomes 0x00 and F becomes 0x0E.
- Every 4-bit input value is legal, so there is no illegal-code or default case visible at the output.
- The blank pattern is 0x00 in lit-segment form, so hex_out is 0x7F when ACTIVE_LOW=1.
- Register update rules, in priority order:
  - rst=1: register goes to the blank pattern.
  - en=1 and blank=1: register captures the blank pattern.
  - en=1 and blank=0: register captures the decode of bin_in.
  - en=0: register holds its value; bin_in and blank are ignored.
- If bin_in contains X or Z while en=1, the output is undefined. There is no requirement to filter this.

## Timing
- Reset: while rst=1, hex_out is the blank pattern (0x7F when ACTIVE_LOW=1), asynchronously and without waiting for a clock edge.
- Releasing rst takes effect without glitching. The first capture happens on the first rising edge at which rst=0 and en=1.
- Latency: 1 cycle. Inputs sampled on rising edge N appear on hex_out right after edge N and stay stable until the next qualifying edge.
- hex_out comes straight from flops, with no combinational path from inputs to output.
- Reset wins over everything. An assertion of rst in the middle of a stream blanks the output at once, and the output stays blank until the first enabled edge after release.
- Back-to-back enabled cycles each update the output. Full throughput is one nibble per clock.
- blank has effect only on enabled edges. If blank falls while en=0, the output remains blank until the next enabled edge.
- There is no handshake and no ready or valid signalling beyond en.

## Test plan
- Reset: assert rst with no clock edge → hex_out=0x7F immediately. Release rst with en=0 and clock 3 cycles → hex_out stays 0x7F.
- Full sweep (ACTIVE_LOW=1): en=1, blank=0, drive bin_in=0..15, one per clock, 10 ns apart. After each edge hex_out must follow 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E.
- Hold: capture bin_in=5 (hex_out=0x12), then set en=0 and change bin_in to 8 for 4 cycles → hex_out stays 0x12.
- Blank: en=1, blank=1, bin_in=8 → hex_out=0x7F after one edge. Drop blank → hex_out=0x00 after the next edge.
- Mid-stream reset: during the sweep, assert rst between edges → hex_out=0x7F before the next edge. Release rst → the decode resumes on the following enabled edge.
- Polarity: with ACTIVE_LOW=0, bin_in=0 → 0x3F, bin_in=F → 0x71. Reset and blank both give 0x00.
